// File: rtl/axis_pkt_sf_buffer.sv
// Store-and-forward AXI-Stream packet buffer: accepts whole packets into a ring RAM,
// drops malformed/oversize/runt packets, and releases only fully committed packets downstream.
module axis_pkt_sf_buffer #(
  parameter int DEPTH_LOG2 = 9,
  parameter int MAX_BEATS  = 190,
  parameter int MIN_BYTES  = 8
) (
  input  logic        aclk,
  input  logic        aresetn,

  input  logic [63:0] S_AXIS_tdata,
  input  logic [7:0]  S_AXIS_tkeep,
  input  logic        S_AXIS_tlast,
  input  logic        S_AXIS_tvalid,
  output logic        S_AXIS_tready,

  output logic [63:0] M_AXIS_tdata,
  output logic [7:0]  M_AXIS_tkeep,
  output logic        M_AXIS_tlast,
  output logic        M_AXIS_tvalid,
  input  logic        M_AXIS_tready,

  output logic [31:0] pkt_count,
  output logic [31:0] drop_count
);

  localparam int AW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = 16;
  localparam int BW    = 73;

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_DROP} state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b0, v[i]};
    return n;
  endfunction

  logic [BW-1:0] mem [DEPTH];
  logic [BW-1:0] ram_rd_q;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] commit_ptr_q, commit_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic [31:0]   pkt_count_q, pkt_count_d;
  logic [31:0]   drop_count_q, drop_count_d;
  logic          rd_vld_q, rd_vld_d;
  logic [BW-1:0] skid0_q, skid0_d;
  logic [BW-1:0] skid1_q, skid1_d;
  logic [1:0]    skid_cnt_q, skid_cnt_d;

  logic [AW-1:0] fill;
  logic          full;
  logic          s_ready, s_hs, wr_en;
  logic [7:0]    keep_p1;
  logic [CW-1:0] beat_nxt, byte_nxt;
  logic          pkt_err, runt;
  logic          m_valid, m_pop, rd_avail, rd_issue;
  logic [2:0]    rd_occ;

  assign fill    = wr_ptr_q - rd_ptr_q;
  assign full    = (fill == AW'(DEPTH));
  // Ready is gated by aresetn so it stays low for the whole reset, not just after the first edge.
  assign s_ready = aresetn && ((state_q == ST_DROP) || !full);
  assign s_hs    = S_AXIS_tvalid && s_ready;
  assign wr_en   = s_hs && (state_q != ST_DROP);

  assign keep_p1  = S_AXIS_tkeep + 8'd1;
  assign beat_nxt = beat_cnt_q + CW'(1);
  assign byte_nxt = byte_cnt_q + CW'(popcount8(S_AXIS_tkeep));

  // A non-last beat that would fill the RAM can never be committed, so it is an error.
  assign pkt_err = (S_AXIS_tkeep == 8'h00)
                || ((S_AXIS_tkeep & keep_p1) != 8'h00)
                || (!S_AXIS_tlast && (S_AXIS_tkeep != 8'hff))
                || (beat_nxt == CW'(MAX_BEATS + 1))
                || (!S_AXIS_tlast && (fill == AW'(DEPTH - 1)));
  assign runt    = S_AXIS_tlast && (byte_nxt < CW'(MIN_BYTES));

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    case (state_q)
      ST_IDLE, ST_RECV: begin
        if (s_hs) begin
          if (pkt_err || runt) begin
            wr_ptr_d     = commit_ptr_q;
            drop_count_d = drop_count_q + 32'd1;
            beat_cnt_d   = '0;
            byte_cnt_d   = '0;
            state_d      = S_AXIS_tlast ? ST_IDLE : ST_DROP;
          end else if (S_AXIS_tlast) begin
            wr_ptr_d     = wr_ptr_q + AW'(1);
            commit_ptr_d = wr_ptr_q + AW'(1);
            pkt_count_d  = pkt_count_q + 32'd1;
            beat_cnt_d   = '0;
            byte_cnt_d   = '0;
            state_d      = ST_IDLE;
          end else begin
            wr_ptr_d   = wr_ptr_q + AW'(1);
            beat_cnt_d = beat_nxt;
            byte_cnt_d = byte_nxt;
            state_d    = ST_RECV;
          end
        end
      end
      ST_DROP: begin
        if (s_hs && S_AXIS_tlast) begin
          beat_cnt_d = '0;
          byte_cnt_d = '0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read side: one RAM read in flight plus a 2-entry skid; a read is issued only when
  // the skid is guaranteed room for it, which sustains one beat per cycle.
  assign m_valid  = (skid_cnt_q != 2'd0);
  assign m_pop    = m_valid && M_AXIS_tready;
  assign rd_avail = (rd_ptr_q != commit_ptr_q);
  assign rd_occ   = 3'(skid_cnt_q) + 3'(rd_vld_q);
  assign rd_issue = rd_avail && ((rd_occ - 3'(m_pop)) < 3'd2);
  assign rd_ptr_d = rd_ptr_q + AW'(rd_issue);
  assign rd_vld_d = rd_issue;

  always_comb begin
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    skid_cnt_d = skid_cnt_q;
    case ({m_pop, rd_vld_q})
      2'b01: begin
        if (skid_cnt_q == 2'd0) skid0_d = ram_rd_q;
        else                    skid1_d = ram_rd_q;
        skid_cnt_d = skid_cnt_q + 2'd1;
      end
      2'b10: begin
        if (skid_cnt_q == 2'd2) skid0_d = skid1_q;
        skid_cnt_d = skid_cnt_q - 2'd1;
      end
      2'b11: begin
        if (skid_cnt_q == 2'd2) begin
          skid0_d = skid1_q;
          skid1_d = ram_rd_q;
        end else begin
          skid0_d = ram_rd_q;
        end
      end
      default: ;
    endcase
  end

  // NOTE: the storage array is deliberately not reset; pointers alone define which entries are live.
  always_ff @(posedge aclk) begin
    if (wr_en)    mem[wr_ptr_q[AW-2:0]] <= {S_AXIS_tlast, S_AXIS_tkeep, S_AXIS_tdata};
    if (rd_issue) ram_rd_q <= mem[rd_ptr_q[AW-2:0]];
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
      rd_vld_q     <= 1'b0;
      skid0_q      <= '0;
      skid1_q      <= '0;
      skid_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
      rd_vld_q     <= rd_vld_d;
      skid0_q      <= skid0_d;
      skid1_q      <= skid1_d;
      skid_cnt_q   <= skid_cnt_d;
    end
  end

  assign S_AXIS_tready = s_ready;
  assign M_AXIS_tvalid = m_valid;
  assign M_AXIS_tlast  = skid0_q[72];
  assign M_AXIS_tkeep  = skid0_q[71:64];
  assign M_AXIS_tdata  = skid0_q[63:0];
  assign pkt_count     = pkt_count_q;
  assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_axis_pkt_sf_buffer.sv
// Directed bench for axis_pkt_sf_buffer: good, runt, oversize, bad-keep, reset and
// backpressure/wrap packets, with outputs collected by a monitor and compared to a queue.
module tb_axis_pkt_sf_buffer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [63:0] S_AXIS_tdata;
  logic [7:0]  S_AXIS_tkeep;
  logic        S_AXIS_tlast;
  logic        S_AXIS_tvalid;
  logic        S_AXIS_tready;
  logic [63:0] M_AXIS_tdata;
  logic [7:0]  M_AXIS_tkeep;
  logic        M_AXIS_tlast;
  logic        M_AXIS_tvalid;
  logic        M_AXIS_tready;
  logic [31:0] pkt_count;
  logic [31:0] drop_count;

  always #5 aclk = ~aclk;

  axis_pkt_sf_buffer dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .S_AXIS_tdata  (S_AXIS_tdata),
    .S_AXIS_tkeep  (S_AXIS_tkeep),
    .S_AXIS_tlast  (S_AXIS_tlast),
    .S_AXIS_tvalid (S_AXIS_tvalid),
    .S_AXIS_tready (S_AXIS_tready),
    .M_AXIS_tdata  (M_AXIS_tdata),
    .M_AXIS_tkeep  (M_AXIS_tkeep),
    .M_AXIS_tlast  (M_AXIS_tlast),
    .M_AXIS_tvalid (M_AXIS_tvalid),
    .M_AXIS_tready (M_AXIS_tready),
    .pkt_count     (pkt_count),
    .drop_count    (drop_count)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [72:0] out_q [$];
  logic [72:0] exp_q [$];

  logic [63:0] dir_d [5] = '{64'hc40c02ca553e16fa, 64'h0000007447c0887a,
                             64'h0100000100030000, 64'h0, 64'h5073930200000000};
  logic [7:0]  dir_k [5] = '{8'hff, 8'hff, 8'hff, 8'hff, 8'h0f};

  // Inputs change only at negedge; a handshake seen at negedge+1 completes on the next posedge.
  always @(negedge aclk) begin
    #1;
    if (aresetn && M_AXIS_tvalid && M_AXIS_tready)
      out_q.push_back({M_AXIS_tlast, M_AXIS_tkeep, M_AXIS_tdata});
  end

  task automatic check(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [7:0] id, input int i);
    return {id, 24'h0, 32'(i)};
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int w;
    S_AXIS_tdata  = d;
    S_AXIS_tkeep  = k;
    S_AXIS_tlast  = l;
    S_AXIS_tvalid = 1'b1;
    w = 0;
    while (!S_AXIS_tready && w < 2000) begin
      @(negedge aclk);
      w++;
    end
    if (w >= 2000) check("s_tready_stall", {72'b0, S_AXIS_tready}, 73'd1);
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic s_idle();
    S_AXIS_tvalid = 1'b0;
    S_AXIS_tlast  = 1'b0;
  endtask

  task automatic send_gen(input logic [7:0] id, input int n, input bit good);
    for (int i = 0; i < n; i++) begin
      send_beat(mk(id, i), 8'hff, (i == n - 1));
      if (good) exp_q.push_back({(i == n - 1), 8'hff, mk(id, i)});
    end
    s_idle();
  endtask

  task automatic send_dir(input bit good);
    for (int i = 0; i < 5; i++) begin
      send_beat(dir_d[i], dir_k[i], (i == 4));
      if (good) exp_q.push_back({(i == 4), dir_k[i], dir_d[i]});
    end
    s_idle();
  endtask

  task automatic drain(input string tag, input int n);
    int w;
    w = 0;
    while (out_q.size() < n && w < 5000) begin
      @(negedge aclk);
      w++;
    end
    check({tag, "_count"}, 73'(out_q.size()), 73'(n));
    for (int i = 0; i < n; i++) begin
      if (out_q.size() > 0 && exp_q.size() > 0)
        check({tag, "_beat"}, out_q.pop_front(), exp_q.pop_front());
    end
  endtask

  initial begin
    aresetn       = 1'b0;
    S_AXIS_tdata  = '0;
    S_AXIS_tkeep  = '0;
    S_AXIS_tlast  = 1'b0;
    S_AXIS_tvalid = 1'b0;
    M_AXIS_tready = 1'b0;
    repeat (3) @(negedge aclk);

    // Reset state
    check("rst_m_tvalid", {72'b0, M_AXIS_tvalid}, 73'd0);
    check("rst_m_beat", {M_AXIS_tlast, M_AXIS_tkeep, M_AXIS_tdata}, 73'd0);
    check("rst_s_tready", {72'b0, S_AXIS_tready}, 73'd0);
    check("rst_pkt_count", 73'(pkt_count), 73'd0);
    check("rst_drop_count", 73'(drop_count), 73'd0);
    aresetn = 1'b1;
    #1;
    check("rel_s_tready", {72'b0, S_AXIS_tready}, 73'd1);
    @(negedge aclk);

    // Directed good packet, held downstream to check first-beat latency
    send_dir(1'b1);
    repeat (3) @(negedge aclk);
    check("dir_latency_valid", {72'b0, M_AXIS_tvalid}, 73'd1);
    check("dir_first_beat", {M_AXIS_tlast, M_AXIS_tkeep, M_AXIS_tdata}, {1'b0, 8'hff, 64'hc40c02ca553e16fa});
    M_AXIS_tready = 1'b1;
    drain("dir", 5);
    check("dir_pkt_count", 73'(pkt_count), 73'd1);
    check("dir_drop_count", 73'(drop_count), 73'd0);

    // Runt: 4 bytes
    send_beat(64'h1122334455667788, 8'h0f, 1'b1);
    s_idle();
    repeat (5) @(negedge aclk);
    check("runt_no_valid", {72'b0, M_AXIS_tvalid}, 73'd0);
    check("runt_no_output", 73'(out_q.size()), 73'd0);
    check("runt_drop_count", 73'(drop_count), 73'd1);
    check("runt_ptrs", 73'(dut.wr_ptr_q), 73'(dut.commit_ptr_q));

    // Oversize: 191 full beats then tlast, followed by a good 2-beat packet
    for (int i = 0; i < 191; i++) send_beat(mk(8'hb0, i), 8'hff, 1'b0);
    send_beat(mk(8'hb0, 191), 8'hff, 1'b1);
    s_idle();
    send_gen(8'hc0, 2, 1'b1);
    drain("ovr", 2);
    repeat (5) @(negedge aclk);
    check("ovr_no_extra", 73'(out_q.size()), 73'd0);
    check("ovr_drop_count", 73'(drop_count), 73'd2);
    check("ovr_pkt_count", 73'(pkt_count), 73'd2);

    // Bad tkeep on beat 2 of 4; remaining beats discarded with ready high
    send_beat(mk(8'hd0, 0), 8'hff, 1'b0);
    send_beat(mk(8'hd0, 1), 8'h0f, 1'b0);
    check("bad_keep_ready3", {72'b0, S_AXIS_tready}, 73'd1);
    send_beat(mk(8'hd0, 2), 8'hff, 1'b0);
    check("bad_keep_ready4", {72'b0, S_AXIS_tready}, 73'd1);
    send_beat(mk(8'hd0, 3), 8'hff, 1'b1);
    s_idle();
    repeat (5) @(negedge aclk);
    check("bad_keep_no_output", 73'(out_q.size()), 73'd0);
    check("bad_keep_drop_count", 73'(drop_count), 73'd3);

    // Reset during beat 3 of a 5-beat packet
    send_beat(dir_d[0], dir_k[0], 1'b0);
    send_beat(dir_d[1], dir_k[1], 1'b0);
    S_AXIS_tdata  = dir_d[2];
    S_AXIS_tkeep  = dir_k[2];
    S_AXIS_tvalid = 1'b1;
    aresetn       = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check("mid_rst_m_tvalid", {72'b0, M_AXIS_tvalid}, 73'd0);
    check("mid_rst_m_beat", {M_AXIS_tlast, M_AXIS_tkeep, M_AXIS_tdata}, 73'd0);
    check("mid_rst_s_tready", {72'b0, S_AXIS_tready}, 73'd0);
    check("mid_rst_drop_count", 73'(drop_count), 73'd0);
    s_idle();
    aresetn = 1'b1;
    #1;
    check("mid_rel_s_tready", {72'b0, S_AXIS_tready}, 73'd1);
    @(negedge aclk);
    send_dir(1'b1);
    drain("post_rst", 5);
    check("post_rst_pkt_count", 73'(pkt_count), 73'd1);
    check("post_rst_drop_count", 73'(drop_count), 73'd0);

    // Filler packet moves the pointers so the next packets straddle the RAM wrap
    send_gen(8'he0, 190, 1'b1);
    drain("filler", 190);

    // Backpressure: two 190-beat packets fit, the third overflows and is dropped
    M_AXIS_tready = 1'b0;
    send_gen(8'h10, 190, 1'b1);
    repeat (4) @(negedge aclk);
    check("bp_hold_valid", {72'b0, M_AXIS_tvalid}, 73'd1);
    check("bp_hold_beat_a", {M_AXIS_tlast, M_AXIS_tkeep, M_AXIS_tdata}, {1'b0, 8'hff, mk(8'h10, 0)});
    repeat (5) @(negedge aclk);
    check("bp_hold_beat_b", {M_AXIS_tlast, M_AXIS_tkeep, M_AXIS_tdata}, {1'b0, 8'hff, mk(8'h10, 0)});
    send_gen(8'h20, 190, 1'b1);
    send_gen(8'h30, 190, 1'b0);
    repeat (3) @(negedge aclk);
    check("bp_pkt_count", 73'(pkt_count), 73'd4);
    check("bp_drop_count", 73'(drop_count), 73'd1);
    check("bp_commit_ptr", 73'(dut.commit_ptr_q), 73'd575);
    check("bp_no_output", 73'(out_q.size()), 73'd0);
    M_AXIS_tready = 1'b1;
    drain("bp", 380);
    repeat (5) @(negedge aclk);
    check("bp_no_extra", 73'(out_q.size()), 73'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
